// File: rtl/precount_host.sv
// rtl/precount_host.sv - host-side command sequencer for the 8-bit preset up/down counter
//
// Purpose: accepts LOAD/RUN/READ commands on a valid/ready port, drives the
// counter's din/load/up/enb pins, reads its tri-stated dout through rdb, counts
// carry pulses during RUN and checks readback against an internal shadow count.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_dir, cmd_data     00 LOAD, 01 RUN, 10 READ, 11 NOP; RUN direction; value / step count
//   rsp_valid/rsp_ready           response handshake (held until accepted)
//   rsp_data, rsp_carries, rsp_err  shadow or sampled dout, RUN carry count, READ mismatch
//   cnt_din, cnt_load, cnt_up     counter preset value, load strobe, direction
//   cnt_enb, cnt_rdb              counter enable and output enable, both active-low
//   cnt_dout, cnt_carry           counter data bus and registered carry
module precount_host #(
  parameter int W    = 8,
  parameter int TURN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic         cmd_dir,
  input  logic [W-1:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [7:0]   rsp_carries,
  output logic         rsp_err,
  output logic [W-1:0] cnt_din,
  output logic         cnt_load,
  output logic         cnt_up,
  output logic         cnt_enb,
  output logic         cnt_rdb,
  input  logic [W-1:0] cnt_dout,
  input  logic         cnt_carry
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, READ, RESP} state_t;

  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [7:0]   TLAST = 8'(TURN);

  state_t       state;
  logic [W-1:0] shadow;
  logic [W-1:0] remain;
  logic [7:0]   tcnt;
  logic [7:0]   cc;
  logic         step_d;
  logic         cc_inc;
  logic [7:0]   cc_next;

  // The counter's carry is registered, so it lines up with the cycle after the
  // enabled step that caused it; step_d marks exactly those cycles.
  always_comb begin
    cc_inc  = step_d && cnt_carry && (cc != 8'hFF);
    cc_next = cc + {7'd0, cc_inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_carries <= 8'd0;
      rsp_err     <= 1'b0;
      cnt_din     <= '0;
      cnt_load    <= 1'b0;
      cnt_up      <= 1'b1;
      cnt_enb     <= 1'b1;
      cnt_rdb     <= 1'b1;
      shadow      <= '0;
      remain      <= '0;
      tcnt        <= 8'd0;
      cc          <= 8'd0;
      step_d      <= 1'b0;
    end else begin
      step_d <= ~cnt_enb;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            case (cmd_op)
              2'b00: begin
                cnt_din  <= cmd_data;
                cnt_load <= 1'b1;
                shadow   <= cmd_data;
                state    <= LOAD;
              end
              2'b01: begin
                cnt_up      <= cmd_dir;
                cc          <= 8'd0;
                rsp_carries <= 8'd0;
                if (cmd_data == '0) begin
                  rsp_data  <= shadow;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
                end else begin
                  cnt_enb <= 1'b0;
                  remain  <= cmd_data;
                  state   <= RUN;
                end
              end
              2'b10: begin
                cnt_rdb <= 1'b0;
                tcnt    <= 8'd0;
                state   <= READ;
              end
              default: begin
                rsp_data    <= shadow;
                rsp_carries <= 8'd0;
                rsp_err     <= 1'b0;
                rsp_valid   <= 1'b1;
                state       <= RESP;
              end
            endcase
          end
        end
        LOAD: begin
          cnt_load    <= 1'b0;
          rsp_data    <= shadow;
          rsp_carries <= 8'd0;
          rsp_err     <= 1'b0;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RUN: begin
          // Each cycle spent here is one enabled counter step.
          shadow <= cnt_up ? shadow + ONE : shadow - ONE;
          cc     <= cc_next;
          remain <= remain - ONE;
          if (remain == ONE) begin
            cnt_enb <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          // Picks up the carry produced by the final step.
          cc          <= cc_next;
          rsp_carries <= cc_next;
          rsp_data    <= shadow;
          rsp_err     <= 1'b0;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        READ: begin
          if (tcnt == TLAST) begin
            cnt_rdb     <= 1'b1;
            rsp_data    <= cnt_dout;
            rsp_err     <= (cnt_dout != shadow);
            rsp_carries <= 8'd0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_precount_host.sv
// tb/tb_precount_host.sv - directed self-checking bench for precount_host
module tb_precount_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [7:0] rsp_carries;
  logic       rsp_err;
  logic [7:0] cnt_din;
  logic       cnt_load;
  logic       cnt_up;
  logic       cnt_enb;
  logic       cnt_rdb;
  logic [7:0] cnt_dout;
  logic       cnt_carry;

  int errors = 0;
  int checks = 0;

  precount_host #(.W(8), .TURN(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dir(cmd_dir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carries(rsp_carries), .rsp_err(rsp_err),
    .cnt_din(cnt_din), .cnt_load(cnt_load), .cnt_up(cnt_up),
    .cnt_enb(cnt_enb), .cnt_rdb(cnt_rdb),
    .cnt_dout(cnt_dout), .cnt_carry(cnt_carry)
  );

  always #5 clk = ~clk;

  // Behavioural model of the external preset counter.
  logic [7:0] cnt_q;
  logic       carry_q;
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 8'h00;
      carry_q <= 1'b0;
    end else if (cnt_load) begin
      cnt_q   <= cnt_din;
      carry_q <= 1'b0;
    end else if (!cnt_enb) begin
      if (cnt_up) {carry_q, cnt_q} <= {1'b0, cnt_q} + 9'd1;
      else begin
        cnt_q   <= cnt_q - 8'd1;
        carry_q <= 1'b0;
      end
    end else begin
      carry_q <= 1'b0;
    end
  end

  assign cnt_carry = carry_q;
  assign cnt_dout  = cnt_rdb ? 8'hzz : (force_en ? force_val : cnt_q);

  // Pin-activity monitors, sampled mid-cycle.
  int enb_low = 0;
  int rdb_low = 0;
  int load_hi = 0;
  int viol    = 0;

  always @(negedge clk) begin
    if (cnt_enb === 1'b0) enb_low++;
    if (cnt_rdb === 1'b0) rdb_low++;
    if (cnt_load === 1'b1) load_hi++;
    if (cnt_rdb === 1'b0 && (cnt_load !== 1'b0 || cnt_enb !== 1'b1)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance with cmd_* scrambled.
  task automatic send(input logic [1:0] op, input logic dir, input logic [7:0] data);
    int t;
    t = 0;
    cmd_op = op; cmd_dir = dir; cmd_data = data; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", 32'(t < 50), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 8'hA5; cmd_dir = ~dir; cmd_op = 2'b11;
  endtask

  task automatic recv(output logic [7:0] d, output logic [7:0] c, output logic e, output int lat);
    int t;
    t = 0;
    while (rsp_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_timeout", 32'(t < 100), 32'd1);
    d = rsp_data; c = rsp_carries; e = rsp_err; lat = t;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [7:0] d, c, d0, c0;
  logic       e, e0;
  int         lat, e_snap, r_snap, l_snap, t;

  initial begin
    // 1: reset held 3 cycles
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_enb", cnt_enb, 1'b1);
      chk("rst_rdb", cnt_rdb, 1'b1);
      chk("rst_load", cnt_load, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
    end
    chk("rst_up", cnt_up, 1'b1);
    chk("rst_rsp_data", rsp_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", cmd_ready, 1'b1);
    chk("rsp_valid_after_release", rsp_valid, 1'b0);

    // 2: LOAD 0xFD, RUN up 5, READ
    send(2'b00, 1'b0, 8'hFD);
    recv(d, c, e, lat);
    chk("load_fd_data", d, 8'hFD);
    e_snap = enb_low;
    send(2'b01, 1'b1, 8'd5);
    recv(d, c, e, lat);
    chk("run_up_enb_cycles", enb_low - e_snap, 5);
    chk("run_up_data", d, 8'h02);
    chk("run_up_carries", c, 8'd1);
    r_snap = rdb_low;
    send(2'b10, 1'b0, 8'h00);
    recv(d, c, e, lat);
    chk("read_02_data", d, 8'h02);
    chk("read_02_err", e, 1'b0);
    chk("read_02_rdb_cycles", rdb_low - r_snap, 2);

    // 3: LOAD 0x03, RUN down 5, READ
    send(2'b00, 1'b0, 8'h03);
    recv(d, c, e, lat);
    e_snap = enb_low;
    send(2'b01, 1'b0, 8'd5);
    recv(d, c, e, lat);
    chk("run_dn_enb_cycles", enb_low - e_snap, 5);
    chk("run_dn_data", d, 8'hFE);
    chk("run_dn_carries", c, 8'd0);
    send(2'b10, 1'b0, 8'h00);
    recv(d, c, e, lat);
    chk("read_fe_data", d, 8'hFE);
    chk("read_fe_err", e, 1'b0);

    // 4: RUN N=0
    e_snap = enb_low;
    send(2'b01, 1'b1, 8'd0);
    recv(d, c, e, lat);
    chk("run0_enb_cycles", enb_low - e_snap, 0);
    chk("run0_latency_ok", 32'(lat <= 1), 32'd1);
    chk("run0_carries", c, 8'd0);
    chk("run0_data", d, 8'hFE);

    // Reserved op behaves as a NOP that still responds
    send(2'b11, 1'b0, 8'h99);
    recv(d, c, e, lat);
    chk("nop_data", d, 8'hFE);
    chk("nop_err", e, 1'b0);

    // 5: forced bus value mismatching shadow
    send(2'b00, 1'b0, 8'h10);
    recv(d, c, e, lat);
    force_en = 1'b1; force_val = 8'h55;
    r_snap = rdb_low;
    send(2'b10, 1'b0, 8'h00);
    recv(d, c, e, lat);
    force_en = 1'b0;
    chk("forced_read_data", d, 8'h55);
    chk("forced_read_err", e, 1'b1);
    chk("forced_rdb_cycles", rdb_low - r_snap, 2);

    // 6: reset during step 3 of a 10-step RUN
    e_snap = enb_low;
    send(2'b01, 1'b1, 8'd10);
    t = 0;
    #1;
    while (enb_low - e_snap < 3 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("run10_reach_step3", enb_low - e_snap, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_run_rst_enb", cnt_enb, 1'b1);
    chk("mid_run_rst_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_no_rsp", rsp_valid, 1'b0);
    send(2'b10, 1'b0, 8'h00);
    recv(d, c, e, lat);
    chk("post_rst_read_data", d, 8'h00);
    chk("post_rst_read_err", e, 1'b0);

    // 7: response backpressure with a competing command presented
    send(2'b10, 1'b0, 8'h00);
    t = 0;
    while (rsp_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_rsp_seen", rsp_valid, 1'b1);
    d0 = rsp_data; c0 = rsp_carries; e0 = rsp_err;
    l_snap = load_hi;
    cmd_op = 2'b00; cmd_data = 8'h77; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid_held", rsp_valid, 1'b1);
      chk("bp_data_stable", {rsp_data, rsp_carries, 7'd0, rsp_err}, {d0, c0, 7'd0, e0});
      chk("bp_cmd_ready_low", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    chk("bp_no_load", load_hi - l_snap, 0);
    chk("bp_read_data", d0, 8'h00);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_released_valid", rsp_valid, 1'b0);
    chk("bp_released_ready", cmd_ready, 1'b1);

    chk("no_load_enb_while_rdb_low", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
